// File: rtl/decode_unit_pkg.sv
// Shared widths, format one-hot codes, functional-unit and access codes for the decode pipeline.
package decode_unit_pkg;

   localparam int unsigned AddressWidth         = 64;
   localparam int unsigned InstructionWidth     = 32;
   localparam int unsigned PidSize              = 20;
   localparam int unsigned TidSize              = 16;
   localparam int unsigned InstCounterWidth     = 64;
   localparam int unsigned InstMinIdWidth       = 7;
   localparam int unsigned OpcodeSize           = 12;
   localparam int unsigned RegAccessPatternSize = 2;
   localparam int unsigned FuncUnitCodeSize     = 3;
   localparam int unsigned FormatWidth          = 25;
   localparam int unsigned OperandWidth         = 5;
   localparam int unsigned ImmWidth             = 64;
   localparam int unsigned BodyWidth            = 4 * OperandWidth + ImmWidth;

   typedef logic [FormatWidth-1:0] format_t;
   typedef logic [5:0]             primary_t;

   localparam format_t FmtI   = 25'h000_0001;
   localparam format_t FmtB   = 25'h000_0002;
   localparam format_t FmtXL  = 25'h000_0004;
   localparam format_t FmtDX  = 25'h000_0008;
   localparam format_t FmtSC  = 25'h000_0010;
   localparam format_t FmtD   = 25'h000_0020;
   localparam format_t FmtX   = 25'h000_0040;
   localparam format_t FmtXO  = 25'h000_0080;
   localparam format_t FmtZ23 = 25'h000_0100;
   localparam format_t FmtA   = 25'h000_0200;
   localparam format_t FmtXS  = 25'h000_0400;
   localparam format_t FmtXFX = 25'h000_0800;
   localparam format_t FmtDS  = 25'h000_1000;
   localparam format_t FmtDQ  = 25'h000_2000;
   localparam format_t FmtVA  = 25'h000_4000;
   localparam format_t FmtVX  = 25'h000_8000;
   localparam format_t FmtVC  = 25'h001_0000;
   localparam format_t FmtMD  = 25'h002_0000;
   localparam format_t FmtMDS = 25'h004_0000;
   localparam format_t FmtXFL = 25'h008_0000;
   localparam format_t FmtZ22 = 25'h010_0000;
   localparam format_t FmtXX2 = 25'h020_0000;
   localparam format_t FmtXX3 = 25'h040_0000;

   typedef enum logic [FuncUnitCodeSize-1:0] {
      FuFx = 3'd0,
      FuLs = 3'd1,
      FuBr = 3'd2,
      FuFp = 3'd3
   } fu_e;

   localparam logic [1:0] RwNone      = 2'b00;
   localparam logic [1:0] RwRead      = 2'b01;
   localparam logic [1:0] RwWrite     = 2'b10;
   localparam logic [1:0] RwReadWrite = 2'b11;

   localparam primary_t OpTdi   = 6'd2;
   localparam primary_t OpTwi   = 6'd3;
   localparam primary_t OpCmpli = 6'd10;
   localparam primary_t OpCmpi  = 6'd11;
   localparam primary_t OpAddi  = 6'd14;
   localparam primary_t OpAddis = 6'd15;
   localparam primary_t OpBc    = 6'd16;
   localparam primary_t OpOris  = 6'd25;
   localparam primary_t OpXoris = 6'd27;
   localparam primary_t OpAndis = 6'd29;
   localparam primary_t OpX31   = 6'd31;
   localparam primary_t OpLsLo  = 6'd32;
   localparam primary_t OpFp59  = 6'd59;
   localparam primary_t OpFp63  = 6'd63;

   localparam logic [4:0] XoIsel = 5'd15;
   localparam logic [4:0] XoFsel = 5'd23;

   function automatic logic is_d_form(input primary_t op);
      return op inside {6'd2, 6'd3, 6'd7, 6'd8, [6'd10:6'd15], [6'd24:6'd29], [6'd32:6'd55]};
   endfunction

   function automatic logic is_fp_a_xo(input logic [4:0] xo);
      return xo inside {5'd18, 5'd20, 5'd21, 5'd22, 5'd24, 5'd25, 5'd26,
                        5'd28, 5'd29, 5'd30, 5'd31};
   endfunction

   function automatic logic is_store(input primary_t op);
      return op inside {[6'd36:6'd39], 6'd44, 6'd45, 6'd47, [6'd52:6'd55]};
   endfunction

endpackage

// File: rtl/decode_format_table.sv
// Combinational lookup from primary opcode and bits 26:30 to format, unit, internal opcode.
module decode_format_table
   import decode_unit_pkg::*;
(
   input  logic [5:0]             primary_i,
   input  logic [4:0]             xo_i,
   output logic [FormatWidth-1:0] format_o,
   output fu_e                    fu_o,
   output logic [OpcodeSize-1:0]  opcode_o,
   output logic                   supported_o
);

   always_comb begin
      format_o    = '0;
      fu_o        = FuFx;
      opcode_o    = {primary_i, 6'b000000};
      supported_o = 1'b0;
      case (primary_i)
         OpFp59, OpFp63: begin
            if (is_fp_a_xo(xo_i) || (primary_i == OpFp63 && xo_i == XoFsel)) begin
               format_o    = FmtA;
               fu_o        = FuFp;
               opcode_o    = {primary_i, 1'b0, xo_i};
               supported_o = 1'b1;
            end
         end
         OpX31: begin
            if (xo_i == XoIsel) begin
               format_o    = FmtA;
               fu_o        = FuFx;
               opcode_o    = {primary_i, 1'b0, xo_i};
               supported_o = 1'b1;
            end
         end
         OpBc: begin
            format_o    = FmtB;
            fu_o        = FuBr;
            supported_o = 1'b1;
         end
         default: begin
            if (is_d_form(primary_i)) begin
               format_o    = FmtD;
               fu_o        = (primary_i >= OpLsLo) ? FuLs : FuFx;
               supported_o = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/decode_unit.sv
// Three-stage PowerPC decoder: register inputs, classify primary/XO, extract operands.
module decode_unit
   import decode_unit_pkg::*;
(
   input  logic                            clock_i,
   input  logic                            reset_i,
   input  logic                            enable_i,
   input  logic                            stall_i,
   input  logic [InstructionWidth-1:0]     instruction_i,
   input  logic [AddressWidth-1:0]         instructionAddress_i,
   input  logic                            is64Bit_i,
   input  logic [PidSize-1:0]              instructionPid_i,
   input  logic [TidSize-1:0]              instructionTid_i,
   input  logic [InstCounterWidth-1:0]     instructionMajId_i,
   output logic                            enableOut,
   output logic [FormatWidth-1:0]          instFormat_o,
   output logic [OpcodeSize-1:0]           opcodeOut,
   output logic [AddressWidth-1:0]         addressOut,
   output logic                            is64BitOut,
   output logic [PidSize-1:0]              pidOut,
   output logic [TidSize-1:0]              tidOut,
   output logic [InstCounterWidth-1:0]     majIDOut,
   output logic [InstMinIdWidth-1:0]       minIDOut,
   output logic [FuncUnitCodeSize-1:0]     funcUnitTypeOut,
   output logic [RegAccessPatternSize-1:0] op1rwOut,
   output logic [RegAccessPatternSize-1:0] op2rwOut,
   output logic [RegAccessPatternSize-1:0] op3rwOut,
   output logic [RegAccessPatternSize-1:0] op4rwOut,
   output logic                            op1IsRegOut,
   output logic                            op2IsRegOut,
   output logic                            op3IsRegOut,
   output logic                            op4IsRegOut,
   output logic [BodyWidth-1:0]            bodyOut
);

   typedef struct packed {
      logic [AddressWidth-1:0]     addr;
      logic                        is64;
      logic [PidSize-1:0]          pid;
      logic [TidSize-1:0]          tid;
      logic [InstCounterWidth-1:0] maj;
   } meta_t;

   // Stage 1: input register.
   logic                        s1_valid_q;
   logic [InstructionWidth-1:0] s1_instr_q;
   meta_t                       s1_meta_q;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         s1_valid_q <= 1'b0;
         s1_instr_q <= '0;
         s1_meta_q  <= '0;
      end else if (!stall_i) begin
         s1_valid_q <= enable_i;
         s1_instr_q <= instruction_i;
         s1_meta_q  <= '{addr: instructionAddress_i, is64: is64Bit_i, pid: instructionPid_i,
                         tid: instructionTid_i, maj: instructionMajId_i};
      end
   end

   // Stage 2: format classification.
   logic [FormatWidth-1:0] tbl_format;
   fu_e                    tbl_fu;
   logic [OpcodeSize-1:0]  tbl_opcode;
   logic                   tbl_supported;

   decode_format_table u_format_table (
      .primary_i   (s1_instr_q[31:26]),
      .xo_i        (s1_instr_q[5:1]),
      .format_o    (tbl_format),
      .fu_o        (tbl_fu),
      .opcode_o    (tbl_opcode),
      .supported_o (tbl_supported)
   );

   logic                        s2_valid_q;
   logic [InstructionWidth-1:0] s2_instr_q;
   meta_t                       s2_meta_q;
   logic [FormatWidth-1:0]      s2_format_q;
   fu_e                         s2_fu_q;
   logic [OpcodeSize-1:0]       s2_opcode_q;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         s2_valid_q  <= 1'b0;
         s2_instr_q  <= '0;
         s2_meta_q   <= '0;
         s2_format_q <= '0;
         s2_fu_q     <= FuFx;
         s2_opcode_q <= '0;
      end else if (!stall_i) begin
         s2_valid_q  <= s1_valid_q & tbl_supported;
         s2_instr_q  <= s1_instr_q;
         s2_meta_q   <= s1_meta_q;
         s2_format_q <= tbl_format;
         s2_fu_q     <= tbl_fu;
         s2_opcode_q <= tbl_opcode;
      end
   end

   // Stage 3: operand extraction.
   logic [5:0]        s2_primary;
   logic [4:0]        s2_xo;
   logic [4:0]        s2_ra;
   logic              ra_zero;
   logic              logical;
   logic              shift16;
   logic              ls;
   logic              update;
   logic [63:0]       d_ext;
   logic              use2, use3, use4;
   logic [3:0][1:0]   rw_d;
   logic [3:0]        isreg_d;
   logic [3:0][4:0]   opnd_d;
   logic [63:0]       imm_d;

   assign s2_primary = s2_instr_q[31:26];
   assign s2_xo      = s2_instr_q[5:1];
   assign s2_ra      = s2_instr_q[20:16];
   assign ra_zero    = (s2_ra == 5'd0);
   assign logical    = (s2_primary >= 6'd24) && (s2_primary <= 6'd29);
   assign shift16    = s2_primary inside {OpAddis, OpOris, OpXoris, OpAndis};
   assign ls         = (s2_primary >= OpLsLo);
   assign update     = ls && s2_primary[0];
   assign d_ext      = logical ? {48'b0, s2_instr_q[15:0]}
                               : {{48{s2_instr_q[15]}}, s2_instr_q[15:0]};

   always_comb begin
      opnd_d    = '0;
      opnd_d[0] = s2_instr_q[25:21];
      opnd_d[1] = s2_instr_q[20:16];
      rw_d      = '0;
      isreg_d   = '0;
      imm_d     = '0;
      use2      = 1'b0;
      use3      = 1'b0;
      use4      = 1'b0;
      if (s2_format_q == FmtA) begin
         opnd_d[2]  = s2_instr_q[15:11];
         opnd_d[3]  = s2_instr_q[10:6];
         rw_d[0]    = RwWrite;
         isreg_d[0] = 1'b1;
         if (s2_primary == OpX31) begin
            // isel: RA=0 selects literal zero; BC names a CR bit, not a register.
            rw_d[1]    = RwRead;
            isreg_d[1] = !ra_zero;
            rw_d[2]    = RwRead;
            isreg_d[2] = 1'b1;
            rw_d[3]    = RwRead;
         end else begin
            case (s2_xo)
               5'd18, 5'd20, 5'd21: begin use2 = 1'b1; use3 = 1'b1; end
               5'd25:               begin use2 = 1'b1; use4 = 1'b1; end
               5'd22, 5'd24, 5'd26: begin use3 = 1'b1; end
               default:             begin use2 = 1'b1; use3 = 1'b1; use4 = 1'b1; end
            endcase
            rw_d[1]    = use2 ? RwRead : RwNone;
            rw_d[2]    = use3 ? RwRead : RwNone;
            rw_d[3]    = use4 ? RwRead : RwNone;
            isreg_d[1] = use2;
            isreg_d[2] = use3;
            isreg_d[3] = use4;
         end
      end else if (s2_format_q == FmtB) begin
         opnd_d[2] = {3'b000, s2_instr_q[1], s2_instr_q[0]};
         rw_d[1]   = RwRead;
         imm_d     = {{48{s2_instr_q[15]}}, s2_instr_q[15:2], 2'b00};
      end else if (s2_format_q == FmtD) begin
         imm_d      = shift16 ? {d_ext[47:0], 16'h0000} : d_ext;
         isreg_d[0] = !(s2_primary inside {OpTdi, OpTwi, OpCmpli, OpCmpi});
         isreg_d[1] = !(ra_zero && (s2_primary == OpAddi || s2_primary == OpAddis ||
                                    (ls && !s2_primary[0])));
         if (logical) begin
            rw_d[0] = RwRead;
            rw_d[1] = RwWrite;
         end else if (is_store(s2_primary)) begin
            rw_d[0] = RwRead;
            rw_d[1] = update ? RwReadWrite : RwRead;
         end else begin
            rw_d[0] = RwWrite;
            rw_d[1] = update ? RwReadWrite : RwRead;
         end
      end
   end

   logic                   out_valid_q;
   logic [FormatWidth-1:0] out_format_q;
   logic [OpcodeSize-1:0]  out_opcode_q;
   fu_e                    out_fu_q;
   meta_t                  out_meta_q;
   logic [3:0][1:0]        out_rw_q;
   logic [3:0]             out_isreg_q;
   logic [BodyWidth-1:0]   out_body_q;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         out_valid_q  <= 1'b0;
         out_format_q <= '0;
         out_opcode_q <= '0;
         out_fu_q     <= FuFx;
         out_meta_q   <= '0;
         out_rw_q     <= '0;
         out_isreg_q  <= '0;
         out_body_q   <= '0;
      end else if (!stall_i) begin
         out_valid_q  <= s2_valid_q;
         out_format_q <= s2_format_q;
         out_opcode_q <= s2_opcode_q;
         out_fu_q     <= s2_fu_q;
         out_meta_q   <= s2_meta_q;
         out_rw_q     <= rw_d;
         out_isreg_q  <= isreg_d;
         out_body_q   <= {opnd_d[0], opnd_d[1], opnd_d[2], opnd_d[3], imm_d};
      end
   end

   assign enableOut       = out_valid_q;
   assign instFormat_o    = out_format_q;
   assign opcodeOut       = out_opcode_q;
   assign funcUnitTypeOut = out_fu_q;
   assign addressOut      = out_meta_q.addr;
   assign is64BitOut      = out_meta_q.is64;
   assign pidOut          = out_meta_q.pid;
   assign tidOut          = out_meta_q.tid;
   assign majIDOut        = out_meta_q.maj;
   assign minIDOut        = '0;
   assign op1rwOut        = out_rw_q[0];
   assign op2rwOut        = out_rw_q[1];
   assign op3rwOut        = out_rw_q[2];
   assign op4rwOut        = out_rw_q[3];
   assign op1IsRegOut     = out_isreg_q[0];
   assign op2IsRegOut     = out_isreg_q[1];
   assign op3IsRegOut     = out_isreg_q[2];
   assign op4IsRegOut     = out_isreg_q[3];
   assign bodyOut         = out_body_q;

endmodule

// File: tb/tb_decode_unit.sv
// Directed vector table plus reset, stall and opcode-sweep sequences for decode_unit.
module tb_decode_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        stall;
   logic [31:0] instr;
   logic [63:0] addr;
   logic        is64;
   logic [19:0] pid;
   logic [15:0] tid;
   logic [63:0] maj;

   logic        enableOut;
   logic [24:0] instFormat;
   logic [11:0] opcodeOut;
   logic [63:0] addressOut;
   logic        is64BitOut;
   logic [19:0] pidOut;
   logic [15:0] tidOut;
   logic [63:0] majIDOut;
   logic [6:0]  minIDOut;
   logic [2:0]  fuOut;
   logic [1:0]  rw1, rw2, rw3, rw4;
   logic        ir1, ir2, ir3, ir4;
   logic [83:0] bodyOut;

   decode_unit dut (
      .clock_i              (clk),
      .reset_i              (rst_n),
      .enable_i             (enable),
      .stall_i              (stall),
      .instruction_i        (instr),
      .instructionAddress_i (addr),
      .is64Bit_i            (is64),
      .instructionPid_i     (pid),
      .instructionTid_i     (tid),
      .instructionMajId_i   (maj),
      .enableOut            (enableOut),
      .instFormat_o         (instFormat),
      .opcodeOut            (opcodeOut),
      .addressOut           (addressOut),
      .is64BitOut           (is64BitOut),
      .pidOut               (pidOut),
      .tidOut               (tidOut),
      .majIDOut             (majIDOut),
      .minIDOut             (minIDOut),
      .funcUnitTypeOut      (fuOut),
      .op1rwOut             (rw1),
      .op2rwOut             (rw2),
      .op3rwOut             (rw3),
      .op4rwOut             (rw4),
      .op1IsRegOut          (ir1),
      .op2IsRegOut          (ir2),
      .op3IsRegOut          (ir3),
      .op4IsRegOut          (ir4),
      .bodyOut              (bodyOut)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // One instruction, then idle; returns #1 after the third rising edge.
   task automatic issue(input logic [31:0] ins);
      @(negedge clk);
      instr  = ins;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   function automatic logic any_output();
      return |{enableOut, instFormat, opcodeOut, addressOut, is64BitOut, pidOut, tidOut,
               majIDOut, minIDOut, fuOut, rw1, rw2, rw3, rw4, ir1, ir2, ir3, ir4, bodyOut};
   endfunction

   typedef struct {
      logic [31:0] ins;
      logic        valid;
      logic [24:0] fmt;
      logic [11:0] opc;
      logic [2:0]  fu;
      logic [7:0]  rw;
      logic [3:0]  isreg;
      logic [83:0] body;
   } vec_t;

   localparam int NumVec = 22;
   vec_t vecs[NumVec];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int na, nv, nb, nd, pulses;
      logic [5:0] bop;

      vecs[0]  = '{32'hFC22182A, 1'b1, 25'd512, 12'hFD5, 3'd3, 8'b10_01_01_00, 4'b1110,
                   {5'd1, 5'd2, 5'd3, 5'd0, 64'd0}};
      vecs[1]  = '{32'h3861FFFC, 1'b1, 25'd32, 12'h380, 3'd0, 8'b10_01_00_00, 4'b1100,
                   {5'd3, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC}};
      vecs[2]  = '{32'h38A01234, 1'b1, 25'd32, 12'h380, 3'd0, 8'b10_01_00_00, 4'b1000,
                   {5'd5, 5'd0, 5'd0, 5'd0, 64'h1234}};
      vecs[3]  = '{32'h3C61FFFF, 1'b1, 25'd32, 12'h3C0, 3'd0, 8'b10_01_00_00, 4'b1100,
                   {5'd3, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_0000}};
      vecs[4]  = '{32'h64A48000, 1'b1, 25'd32, 12'h640, 3'd0, 8'b01_10_00_00, 4'b1100,
                   {5'd5, 5'd4, 5'd0, 5'd0, 64'h8000_0000}};
      vecs[5]  = '{32'h60A48000, 1'b1, 25'd32, 12'h600, 3'd0, 8'b01_10_00_00, 4'b1100,
                   {5'd5, 5'd4, 5'd0, 5'd0, 64'h8000}};
      vecs[6]  = '{32'h80610008, 1'b1, 25'd32, 12'h800, 3'd1, 8'b10_01_00_00, 4'b1100,
                   {5'd3, 5'd1, 5'd0, 5'd0, 64'd8}};
      vecs[7]  = '{32'h8060FFFC, 1'b1, 25'd32, 12'h800, 3'd1, 8'b10_01_00_00, 4'b1000,
                   {5'd3, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC}};
      vecs[8]  = '{32'h9461FFF0, 1'b1, 25'd32, 12'h940, 3'd1, 8'b01_11_00_00, 4'b1100,
                   {5'd3, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFF0}};
      vecs[9]  = '{32'h84610004, 1'b1, 25'd32, 12'h840, 3'd1, 8'b10_11_00_00, 4'b1100,
                   {5'd3, 5'd1, 5'd0, 5'd0, 64'd4}};
      vecs[10] = '{32'h90600000, 1'b1, 25'd32, 12'h900, 3'd1, 8'b01_01_00_00, 4'b1000,
                   {5'd3, 5'd0, 5'd0, 5'd0, 64'd0}};
      vecs[11] = '{32'h2C830005, 1'b1, 25'd32, 12'h2C0, 3'd0, 8'b10_01_00_00, 4'b0100,
                   {5'd4, 5'd3, 5'd0, 5'd0, 64'd5}};
      vecs[12] = '{32'h41820008, 1'b1, 25'd2, 12'h400, 3'd2, 8'b00_01_00_00, 4'b0000,
                   {5'd12, 5'd2, 5'd0, 5'd0, 64'd8}};
      vecs[13] = '{32'h4200FFFD, 1'b1, 25'd2, 12'h400, 3'd2, 8'b00_01_00_00, 4'b0000,
                   {5'd16, 5'd0, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC}};
      vecs[14] = '{32'hFC220132, 1'b1, 25'd512, 12'hFD9, 3'd3, 8'b10_01_00_01, 4'b1101,
                   {5'd1, 5'd2, 5'd0, 5'd4, 64'd0}};
      vecs[15] = '{32'hFCA0302C, 1'b1, 25'd512, 12'hFD6, 3'd3, 8'b10_00_01_00, 4'b1010,
                   {5'd5, 5'd0, 5'd6, 5'd0, 64'd0}};
      vecs[16] = '{32'hEC22193A, 1'b1, 25'd512, 12'hEDD, 3'd3, 8'b10_01_01_01, 4'b1111,
                   {5'd1, 5'd2, 5'd3, 5'd4, 64'd0}};
      vecs[17] = '{32'h7C60209E, 1'b1, 25'd512, 12'h7CF, 3'd0, 8'b10_01_01_01, 4'b1010,
                   {5'd3, 5'd0, 5'd4, 5'd2, 64'd0}};
      vecs[18] = '{32'hFC22192E, 1'b1, 25'd512, 12'hFD7, 3'd3, 8'b10_01_01_01, 4'b1111,
                   {5'd1, 5'd2, 5'd3, 5'd4, 64'd0}};
      vecs[19] = '{32'h7C000000, 1'b0, '0, '0, '0, '0, '0, '0};
      vecs[20] = '{32'hEC00002E, 1'b0, '0, '0, '0, '0, '0, '0};
      vecs[21] = '{32'h00000000, 1'b0, '0, '0, '0, '0, '0, '0};

      rst_n  = 1'b0;
      enable = 1'b0;
      stall  = 1'b0;
      instr  = '0;
      addr   = '0;
      is64   = 1'b0;
      pid    = '0;
      tid    = '0;
      maj    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_enable", enableOut, 1'b0);
      chk("reset_outputs_zero", any_output(), 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NumVec; i++) begin
         addr = 64'hC000_0000_0000_1000 + 64'(i * 4);
         is64 = i[0];
         pid  = 20'hA5000 + 20'(i);
         tid  = 16'h5A00 + 16'(i);
         maj  = 64'd100 + 64'(i);
         issue(vecs[i].ins);
         chk($sformatf("v%0d_enable", i), enableOut, vecs[i].valid);
         if (vecs[i].valid) begin
            chk($sformatf("v%0d_format", i), instFormat, vecs[i].fmt);
            chk($sformatf("v%0d_opcode", i), opcodeOut, vecs[i].opc);
            chk($sformatf("v%0d_fu", i), fuOut, vecs[i].fu);
            chk($sformatf("v%0d_rw", i), {rw1, rw2, rw3, rw4}, vecs[i].rw);
            chk($sformatf("v%0d_isreg", i), {ir1, ir2, ir3, ir4}, vecs[i].isreg);
            chk($sformatf("v%0d_body", i), bodyOut, vecs[i].body);
            chk($sformatf("v%0d_passthru", i),
                {addressOut, is64BitOut, pidOut, tidOut, majIDOut, minIDOut},
                {addr, is64, pid, tid, maj, 7'd0});
         end
      end

      // Reset while two instructions are in flight.
      issue(32'hFC22182A);
      @(negedge clk);
      instr  = 32'h3861FFFC;
      enable = 1'b1;
      @(negedge clk);
      instr  = 32'hFC22182A;
      @(negedge clk);
      enable = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("inflight_reset_enable", enableOut, 1'b0);
      chk("inflight_reset_outputs_zero", any_output(), 1'b0);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (enableOut) pulses++;
      end
      chk("inflight_reset_no_emerge", pulses, 0);

      // Stall for two edges with fadd in stage 2; enable_i during stall must be ignored.
      @(negedge clk);
      instr  = 32'hFC22182A;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      stall  = 1'b1;
      enable = 1'b1;
      instr  = 32'h3861FFFC;
      @(posedge clk);
      #1;
      chk("stall_edge1_enable", enableOut, 1'b0);
      @(posedge clk);
      #1;
      chk("stall_edge2_enable", enableOut, 1'b0);
      @(negedge clk);
      stall  = 1'b0;
      enable = 1'b0;
      @(posedge clk);
      #1;
      chk("stall_release_enable", enableOut, 1'b1);
      chk("stall_release_format", instFormat, 25'd512);
      chk("stall_release_opcode", opcodeOut, 12'hFD5);
      pulses = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (enableOut) pulses++;
      end
      chk("stall_no_duplicate", pulses, 0);

      // Full primary x bits 26:30 sweep.
      na = 0;
      nv = 0;
      for (int op = 0; op < 64; op++) begin
         for (int x = 0; x < 32; x++) begin
            issue({6'(op), 20'd0, 5'(x), 1'b0});
            if (enableOut) nv++;
            if (enableOut && instFormat == 25'd512) na++;
         end
      end
      chk("sweep_a_form_count", na, 24);
      chk("sweep_total_valid", nv, 24 + 32 * 41);

      // Primary-only sweep for B and D forms.
      nb  = 0;
      nd  = 0;
      bop = '0;
      for (int op = 0; op < 64; op++) begin
         issue({6'(op), 26'd0});
         if (enableOut && instFormat == 25'd2) begin
            nb++;
            bop = 6'(op);
         end
         if (enableOut && instFormat == 25'd32) nd++;
      end
      chk("sweep_b_count", nb, 1);
      chk("sweep_b_opcode", bop, 6'd16);
      chk("sweep_d_count", nd, 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_unit.md
# decode_unit

Three-stage pipelined instruction decoder for the PowerPC front end. It sits between fetch and rename/issue. Each cycle it accepts one 32-bit big-endian instruction with its address, PID, TID and major ID. It emits the instruction format, an internal opcode, the functional-unit class, per-operand access flags and a packed operand body. Supported subset: A-form (24 instructions), B-form (bc) and D-form (40 opcodes); all other encodings are dropped.

## Interface
- addressWidth, 64, instruction address width
- instructionWidth, 32, instruction width
- PidSize / TidSize, 20 / 16, process / thread ID widths
- instructionCounterWidth, 64, major ID width
- instMinIdWidth, 7, minor ID width
- opcodeSize, 12, internal opcode width
- regAccessPatternSize, 2, operand access flags
- funcUnitCodeSize, 3, functional-unit code width

Ports (bit 0 = MSB, Power ISA numbering):
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- enable_i  in  1  instruction valid
- stall_i  in  1  freeze whole pipe
- instruction_i  in  32  instruction word
- instructionAddress_i  in  64  instruction address
- is64Bit_i  in  1  64-bit mode flag
- instructionPid_i  in  20  process ID
- instructionTid_i  in  16  thread ID
- instructionMajId_i  in  64  major ID
- enableOut  out  1  output valid
- instFormat_o  out  25  one-hot format: I=2^0, B=2^1, XL=2^2, DX=2^3, SC=2^4, D=2^5, X=2^6, XO=2^7, Z23=2^8, A=2^9, XS=2^10, XFX=2^11, DS=2^12, DQ=2^13, VA=2^14, VX=2^15, VC=2^16, MD=2^17, MDS=2^18, XFL=2^19, Z22=2^20, XX2=2^21, XX3=2^22
- opcodeOut  out  12  A-form: {primary[0:5], 0, XO[26:30]}; B/D-form: {primary, 6'b0}
- addressOut, is64BitOut, pidOut, tidOut, majIDOut  out  64/1/20/16/64  passed through
- minIDOut  out  7  always 0; no cracking
- funcUnitTypeOut  out  3  0=FX, 1=LS, 2=BR, 3=FP
- op1rwOut..op4rwOut  out  2 each  [0]=read, [1]=written; unused operand = 00
- op1IsRegOut..op4IsRegOut  out  1 each  operand is a GPR/FPR
- bodyOut  out  84  [0:4]=op1, [5:9]=op2, [10:14]=op3, [15:19]=op4, [20:83]=64-bit immediate

## Operation
- A-form, op1..op4 = bits 6:10, 11:15, 16:20, 21:25; op1 written, op2..op4 read; immediate 0.
  - Opcode 59, XO 18, 20, 21, 22, 24, 25, 26, 28, 29, 30, 31: FP.
  - Opcode 63, same XO set plus 23 (fsel): FP.
  - Opcode 31, XO 15 (isel): FX; op2 isReg=0 when RA=0; op4 (BC) isReg=0, read.
  - FP operand usage:
    - add/sub/div: ops 2, 3
    - mul: ops 2, 4
    - sqrt/re/rsqrte: op 3 only
    - fsel/fma family: ops 2, 3, 4
    - Unused operands: isReg 0, rw 00.
- B-form, opcode 16, BR:
  - op1 = BO, op2 = BI; both isReg 0, op2 read.
  - op3 = {000, AA, LK}, isReg 0.
  - Immediate = sign-extended BD(16:29) << 2.
- D-form opcodes:
  - FX: 2, 3, 7, 8, 10–15, 24–29
  - LS: 32–47
  - LS (FP load/store): 48–55
  - op1 = bits 6:10, op2 = bits 11:15.
  - Immediate = sign-extended D(16:31). Logical ops 24–29 zero-extend D. Opcodes 15, 25, 27, 29 shift it left 16.
  - Loads, arithmetic: op1 written, op2 read.
  - Stores: op1 and op2 read.
  - Update forms (odd 33–55): op2 read+written.
  - Logical immediates: op1 read, op2 written.
  - Traps (2, 3) and compares (10, 11): op1 isReg 0.
  - addi, addis and non-update loads/stores: op2 isReg 0 when RA=0.
- Unsupported encodings: enableOut stays 0 for that slot.

## Timing
- Stage 1 registers inputs; stage 2 decodes primary/XO; stage 3 extracts operands into the output register.
- Latency 3 rising edges: enableOut is high in the cycle after the third edge, for one cycle per accepted instruction. Throughput 1/cycle.
- stall_i high: every stage holds, enable_i is ignored and outputs hold their value. Upstream must keep the instruction presented.
- reset_i low, asynchronous, any time: all valid bits and all outputs go to 0 and in-flight instructions are discarded.

## Structure
- Shared package holds the format one-hot constants, FU codes, rw codes and primary-opcode constants.
- One combinational sub-module, decode_format_table: primary opcode plus bits 26:30 in; format, FU, opcode and supported flag out.

## Test plan
- Reset_i low with two instructions in flight -> enableOut=0 and all outputs 0; nothing emerges afterwards.
- Present 0xFC22182A (fadd f1,f2,f3) -> after 3 edges:
  - enableOut=1, format=512, FU=3, opcode=0xFD5
  - op1=1 (W), op2=2 (R), op3=3 (R), op4 rw 00
- Sweep opcodes 0–63 × bits 26:30 0–31, one instruction per 3 cycles -> exactly 24 results with format 512.
- Sweep opcodes 0–63 -> exactly one B (opcode 16, format 2) and exactly 40 D (format 32).
- 0x3861FFFC (addi r3,r1,-4) -> op1=3 W, op2=1 R, imm=0xFFFF_FFFF_FFFF_FFFC, FU=0.
- Assert stall_i for 2 cycles with an instruction in stage 2 -> enableOut delayed exactly 2 cycles, single pulse, no duplicate.
